// File: rtl/debouncer_bank_pkg.sv
// Shared helpers for the debouncer bank: counter sizing and timing-conversion macros.
`ifndef DEBOUNCER_BANK_COMMON
`define DEBOUNCER_BANK_COMMON
// Time in microseconds expressed in nanoseconds, and in clock cycles for a clock given in MHz.
`define US(t) ((t) * 1000)
`define C_US(f_mhz, t) ((f_mhz) * (t))
`endif

package debouncer_bank_pkg;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter must hold values up to the larger of the two hold limits.
    function automatic int unsigned cnt_width(input int unsigned cmax_r, input int unsigned cmax_f);
        return $clog2(max_u(cmax_r, cmax_f) + 1);
    endfunction

endpackage

// File: rtl/debouncer_bank_ch.sv
// One debounced channel: synchronizer, hold counter, stable level and edge strobes.
module debouncer_ch
    import debouncer_bank_pkg::*;
#(
    parameter int unsigned DEB_CMAX_R = 1000,
    parameter int unsigned DEB_CMAX_F = 1000,
    parameter int unsigned SYNC_N     = 2,
    parameter logic        INIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a_sig,
    output logic d_sig,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CW = cnt_width(DEB_CMAX_R, DEB_CMAX_F);
    localparam logic [CW-1:0] LAST_R = CW'(DEB_CMAX_R - 1);
    localparam logic [CW-1:0] LAST_F = CW'(DEB_CMAX_F - 1);

    logic [SYNC_N-1:0] sync_reg;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              d_reg, d_next;
    logic              rise_reg, rise_next;
    logic              fall_reg, fall_next;
    logic              s;

    assign s = sync_reg[SYNC_N-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {SYNC_N{INIT}};
        end else begin
            sync_reg <= {sync_reg[SYNC_N-2:0], a_sig};
        end
    end

    // Any sample that agrees with the stable level discards the partial count.
    always_comb begin
        cnt_next  = cnt_reg;
        d_next    = d_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (s == d_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == (d_reg ? LAST_F : LAST_R)) begin
            cnt_next  = '0;
            d_next    = s;
            rise_next = s;
            fall_next = ~s;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            d_reg    <= INIT;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            d_reg    <= d_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    assign d_sig = d_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;
    assign busy  = (cnt_reg != '0);

endmodule

// File: rtl/debouncer_bank.sv
// Bank of independent debounced channels with per-channel edge strobes.
module debouncer_bank
    import debouncer_bank_pkg::*;
#(
    parameter int unsigned       CH         = 4,
    parameter int unsigned       DEB_CMAX_R = 1000,
    parameter int unsigned       DEB_CMAX_F = 1000,
    parameter int unsigned       SYNC_N     = 2,
    parameter logic [CH-1:0]     INIT       = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] a_sig,
    output logic [CH-1:0] d_sig,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] busy
);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            debouncer_ch #(
                .DEB_CMAX_R (DEB_CMAX_R),
                .DEB_CMAX_F (DEB_CMAX_F),
                .SYNC_N     (SYNC_N),
                .INIT       (INIT[gi])
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .a_sig (a_sig[gi]),
                .d_sig (d_sig[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi]),
                .busy  (busy[gi])
            );
        end
    endgenerate

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Multi-channel successor to the single-input debouncer. It samples `CH` asynchronous inputs (buttons, switches) through a configurable synchronizer. Each channel is filtered independently, with separate press (rising) and release (falling) hold times. The block outputs clean levels plus single-cycle rise/fall event strobes. It sits between the board I/O and the control logic, so downstream FSMs can consume edge events without their own edge detectors.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `DEB_CMAX_R`, 1000: cycles a synchronized input must stay 1 (while output is 0) before the output rises (≥1).
- `DEB_CMAX_F`, 1000: cycles a synchronized input must stay 0 (while output is 1) before the output falls (≥1).
- `SYNC_N`, 2: synchronizer depth in flops (≥2).
- `INIT`, {CH{1'b0}}: reset value of synchronizer flops and stable outputs, per channel.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_sig`  in  CH  raw asynchronous inputs.
- `d_sig`  out  CH  debounced stable levels; reset = `INIT`.
- `rise`  out  CH  one-cycle strobe when `d_sig[i]` goes 0→1; reset = 0.
- `fall`  out  CH  one-cycle strobe when `d_sig[i]` goes 1→0; reset = 0.
- `busy`  out  CH  channel counter nonzero, i.e. a transition is pending; reset = 0.

## Operation
- Per channel: `s[i]` is `a_sig[i]` after `SYNC_N` flops. Counter `cnt[i]` width is `$clog2(max(DEB_CMAX_R,DEB_CMAX_F)+1)`.
- Effective limit: `lim = DEB_CMAX_R` when `d_sig[i]==0`, else `DEB_CMAX_F`.
- Each cycle:
  - If `s[i] == d_sig[i]`: `cnt` ← 0. Any partial count is discarded, so a glitch shorter than `lim` is fully rejected.
  - Else if `cnt == lim-1`:
    - `d_sig[i]` ← `s[i]`.
    - `cnt` ← 0.
    - `rise[i]` or `fall[i]` ← 1 for exactly this next cycle.
  - Else: `cnt` ← `cnt+1`. The counter never wraps; saturation is impossible by construction.
- Strobes are registered and deasserted in every cycle that has no transition. `rise` and `fall` are never both high in the same channel.
- Channels are fully independent. Any mix of simultaneous transitions across channels produces simultaneous strobes.
- `busy[i] = (cnt[i] != 0)`, combinational from the counter.
- Reset mid-operation (asynchronous `rst`):
  - Synchronizer flops and `d_sig` take `INIT`.
  - Counters, `rise` and `fall` clear immediately, with no strobe generated.
  - After release, a channel whose input differs from `INIT` starts counting normally.

## Timing
- Let cycle 0 be the first edge at which `s[i]` differs from `d_sig[i]` (`SYNC_N` edges after `a_sig` is captured).
- `d_sig[i]` and the strobe change after edge `lim-1`, i.e. they are visible `lim` cycles after cycle 0.
- Total latency from a clean step on `a_sig` = `SYNC_N + lim` cycles, ±1 for synchronizer metastability resolution.
- Minimum interval between two strobes on one channel: `lim` of the second transition.
- A pulse of `s[i]` lasting exactly `lim-1` cycles produces no change. A pulse of exactly `lim` cycles produces a change.
- No combinational path from `a_sig` to any output.

## Structure
- `debouncer_ch` holds one channel: synchronizer, counter, stable flop and strobe flops. It takes the same parameters, scalar.
- `debouncer_bank` is a generate loop over `CH` instances plus bus concatenation.
- The counter-width helper (clog2/max) and the `c_us`/`us` timing macros go in the shared common header. No per-module constants are duplicated.

## Test plan
Bench parameters: `CH=4`, `DEB_CMAX_R=8`, `DEB_CMAX_F=4`, `SYNC_N=2`, `INIT=4'b0000`.

- **Clean press:** `a_sig[0]` 0→1 and held.
  - `d_sig[0]` rises exactly 10 cycles after capture.
  - `rise[0]` is high for one cycle in the same cycle.
  - `busy[0]` is high for the 7 preceding cycles.
- **Glitch rejection:**
  - `a_sig[1]` high for 7 cycles → no `d_sig`/`rise` change and `busy` returns to 0.
  - Repeat with 8 cycles → rise occurs.
- **Asymmetric release:** after a stable 1, `a_sig[2]` drops.
  - `d_sig[2]` falls after 4+2 cycles with `fall[2]` single-cycle.
  - A 3-cycle low dip causes no fall.
- **Simultaneous channels:** all 4 inputs step 0→1 on the same cycle.
  - All `rise` bits assert together in one cycle.
  - Then all step 1→0, and `fall=4'b1111` appears 4 cycles after the falling edges reach `s`.
- **Reset mid-count:**
  - Assert `rst` for 1 cycle when `cnt[3]=5` → all outputs `INIT`/0 immediately with no strobe.
  - After release with `a_sig[3]` still 1, the rise comes a full 10 cycles later.
- **Bounce train:** `a_sig[0]` toggles every 3 cycles for 60 cycles, then settles at 1.
  - Exactly one `rise[0]` occurs, 10 cycles after settling, with zero `fall[0]`.
